// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
// Bundles the signals around the register-file write port arbiter:
//   - pipeline write-back request (wb_en_i, wb_addr_i, wb_data_i)
//   - host/debug write request and handshake (dbg_valid_i, dbg_addr_i,
//     dbg_data_i, dbg_ready_o, dbg_count_o)
//   - clear-sequence status (init_busy_o)
//   - register-file write port (rf_we_o, rf_waddr_o, rf_wdata_o)
// master modport: the surrounding pipeline/host side.
// slave modport : the arbiter itself.
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
    parameter int FIFO_DEPTH = 2
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             wb_en_i;
    logic [4:0]       wb_addr_i;
    logic [31:0]      wb_data_i;
    logic             dbg_valid_i;
    logic [4:0]       dbg_addr_i;
    logic [31:0]      dbg_data_i;
    logic             dbg_ready_o;
    logic [CNT_W-1:0] dbg_count_o;
    logic             init_busy_o;
    logic             rf_we_o;
    logic [4:0]       rf_waddr_o;
    logic [31:0]      rf_wdata_o;

    modport master (
        output wb_en_i, wb_addr_i, wb_data_i,
        output dbg_valid_i, dbg_addr_i, dbg_data_i,
        input  dbg_ready_o, dbg_count_o, init_busy_o,
        input  rf_we_o, rf_waddr_o, rf_wdata_o
    );

    modport slave (
        input  wb_en_i, wb_addr_i, wb_data_i,
        input  dbg_valid_i, dbg_addr_i, dbg_data_i,
        output dbg_ready_o, dbg_count_o, init_busy_o,
        output rf_we_o, rf_waddr_o, rf_wdata_o
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
// Owns the single register-file write port. After reset an optional clear
// sequence writes INIT_VALUE to r0..r31 (one register per cycle) while
// init_busy_o holds the pipeline. Afterwards the port is granted to the
// pipeline write-back whenever wb_en_i is set; otherwise the head of a small
// host write FIFO is retired. Host writes to r0 are popped but suppressed.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - regfile_write_arbiter_if.slave (write-back, host, rf port, status)
// Write-port outputs are combinational so a write-back request reaches the
// register file in the same cycle.
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
    parameter int          FIFO_DEPTH = 2,
    parameter int          INIT_CLEAR = 1,
    parameter logic [31:0] INIT_VALUE = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    regfile_write_arbiter_if.slave   bus
);
    localparam int               PTR_W       = $clog2(FIFO_DEPTH);
    localparam int               CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      IDLE_DATA_C = 32'hDEAD_BEEF;
    localparam logic [4:0]       LAST_IDX_C  = 5'd31;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [4:0]       init_idx_r;
    logic [4:0]       fifo_addr_r [FIFO_DEPTH];
    logic [31:0]      fifo_data_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;

    logic             ready_s;
    logic             push_s;
    logic             pop_s;
    logic [4:0]       head_addr_s;
    logic [31:0]      head_data_s;
    logic             rf_we_s;
    logic [4:0]       rf_waddr_s;
    logic [31:0]      rf_wdata_s;
    logic             init_busy_s;

    assign head_addr_s = fifo_addr_r[rd_ptr_r];
    assign head_data_s = fifo_data_r[rd_ptr_r];

    // Ready is 0 during reset and INIT, so no push can happen then.
    assign push_s = bus.dbg_valid_i && ready_s;

    assign bus.dbg_ready_o = ready_s;
    assign bus.dbg_count_o = count_r;
    assign bus.init_busy_o = init_busy_s;
    assign bus.rf_we_o     = rf_we_s;
    assign bus.rf_waddr_o  = rf_waddr_s;
    assign bus.rf_wdata_o  = rf_wdata_s;

    // Next state, write-port mux, FIFO pop and host ready.
    always_comb begin
        state_nxt_s = state_r;
        rf_we_s     = 1'b0;
        rf_waddr_s  = 5'd0;
        rf_wdata_s  = IDLE_DATA_C;
        init_busy_s = 1'b0;
        ready_s     = 1'b0;
        pop_s       = 1'b0;
        if (rst) begin
            // Reset overrides everything; busy reflects whether a clear follows.
            init_busy_s = (INIT_CLEAR != 0);
        end else begin
            case (state_r)
                ST_INIT: begin
                    rf_we_s     = 1'b1;
                    rf_waddr_s  = init_idx_r;
                    rf_wdata_s  = INIT_VALUE;
                    init_busy_s = 1'b1;
                    if (init_idx_r == LAST_IDX_C) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_INIT;
                    end
                end
                ST_RUN: begin
                    // Ready uses registered occupancy only, not this cycle's pop.
                    ready_s = (count_r < DEPTH_C);
                    if (bus.wb_en_i) begin
                        rf_we_s    = 1'b1;
                        rf_waddr_s = bus.wb_addr_i;
                        rf_wdata_s = bus.wb_data_i;
                    end else if (count_r != {CNT_W{1'b0}}) begin
                        // r0 entries still drain, but never reach the file.
                        pop_s      = 1'b1;
                        rf_we_s    = (head_addr_s != 5'd0);
                        rf_waddr_s = head_addr_s;
                        rf_wdata_s = head_data_s;
                    end else begin
                        rf_we_s    = 1'b0;
                        rf_waddr_s = 5'd0;
                        rf_wdata_s = IDLE_DATA_C;
                    end
                end
                default: begin
                    // Unreachable encoding: restart through the clear path.
                    state_nxt_s = ST_INIT;
                end
            endcase
        end
    end

    // State, clear index, FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= (INIT_CLEAR != 0) ? ST_INIT : ST_RUN;
            init_idx_r <= 5'd0;
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_INIT) begin
                init_idx_r <= init_idx_r + 5'd1;
            end
            // Power-of-2 depth: pointers wrap naturally.
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= bus.dbg_addr_i;
            fifo_data_r[wr_ptr_r] <= bus.dbg_data_i;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
// Self-checking bench: a queue-based reference model predicts the write port,
// handshake and status outputs every cycle; directed scenarios add literal
// expectations, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] INIT_VAL = 32'h0000_0000;
    localparam logic [31:0] IDLE     = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_write_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();

    regfile_write_arbiter #(
        .FIFO_DEPTH(DEPTH),
        .INIT_CLEAR(1),
        .INIT_VALUE(INIT_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t q[$];
    int   m_init_left = 0;
    bit   m_accepted  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    endtask

    // Advance the model across one rising edge using the inputs held now.
    task automatic tick();
        bit r;
        @(posedge clk);
        m_accepted = 1'b0;
        if (rst) begin
            m_init_left = 32;
            q.delete();
        end else if (m_init_left > 0) begin
            m_init_left--;
        end else begin
            r = (q.size() < DEPTH);
            m_accepted = bus.dbg_valid_i && r;
            if (!bus.wb_en_i && q.size() > 0) void'(q.pop_front());
            if (m_accepted) q.push_back('{a: bus.dbg_addr_i, d: bus.dbg_data_i});
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic dv, input logic [4:0] da, input logic [31:0] dd);
        #1;
        rst             = r;
        bus.wb_en_i     = we;
        bus.wb_addr_i   = wa;
        bus.wb_data_i   = wd;
        bus.dbg_valid_i = dv;
        bus.dbg_addr_i  = da;
        bus.dbg_data_i  = dd;
    endtask

    // Compare every DUT output against what the model says it must be.
    task automatic check_model();
        logic        e_we, e_rdy, e_busy;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        #4;
        e_we = 1'b0; e_a = 5'd0; e_d = IDLE; e_rdy = 1'b0; e_busy = 1'b0;
        if (rst) begin
            e_busy = 1'b1;
        end else if (m_init_left > 0) begin
            e_we = 1'b1; e_a = 5'(32 - m_init_left); e_d = INIT_VAL; e_busy = 1'b1;
        end else begin
            e_rdy = (q.size() < DEPTH);
            if (bus.wb_en_i) begin
                e_we = 1'b1; e_a = bus.wb_addr_i; e_d = bus.wb_data_i;
            end else if (q.size() > 0) begin
                e_we = (q[0].a != 5'd0); e_a = q[0].a; e_d = q[0].d;
            end
        end
        chk("rf_we",     32'(bus.rf_we_o),     32'(e_we));
        chk("rf_waddr",  32'(bus.rf_waddr_o),  32'(e_a));
        chk("rf_wdata",  bus.rf_wdata_o,       e_d);
        chk("dbg_ready", 32'(bus.dbg_ready_o), 32'(e_rdy));
        chk("dbg_count", 32'(bus.dbg_count_o), 32'(q.size()));
        chk("init_busy", 32'(bus.init_busy_o), 32'(e_busy));
    endtask

    task automatic step(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic dv, input logic [4:0] da, input logic [31:0] dd);
        tick();
        drive(r, we, wa, wd, dv, da, dd);
        check_model();
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        logic        p_valid;
        logic [4:0]  p_a;
        logic [31:0] p_d;
        logic        r_rst, r_wb;

        rst = 1'b1;
        bus.wb_en_i = 1'b0; bus.wb_addr_i = 5'd0; bus.wb_data_i = 32'd0;
        bus.dbg_valid_i = 1'b0; bus.dbg_addr_i = 5'd0; bus.dbg_data_i = 32'd0;

        // Reset held
        idle(1'b1);
        idle(1'b1);
        chk("rst_wdata", bus.rf_wdata_o, 32'hDEAD_BEEF);
        chk("rst_busy",  32'(bus.init_busy_o), 32'd1);
        chk("rst_we",    32'(bus.rf_we_o), 32'd0);

        // Clear sequence r0..r31
        for (int k = 0; k < 32; k++) begin
            idle(1'b0);
            chk("init_addr", 32'(bus.rf_waddr_o), 32'(k));
            chk("init_rdy",  32'(bus.dbg_ready_o), 32'd0);
        end
        idle(1'b0);
        chk("run_busy", 32'(bus.init_busy_o), 32'd0);
        chk("run_rdy",  32'(bus.dbg_ready_o), 32'd1);

        // Back-to-back host pushes
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h0000_AAAA);
        chk("bb1_we", 32'(bus.rf_we_o), 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h0000_BBBB);
        chk("bb2_addr", 32'(bus.rf_waddr_o), 32'd3);
        chk("bb2_data", bus.rf_wdata_o, 32'h0000_AAAA);
        chk("bb2_rdy",  32'(bus.dbg_ready_o), 32'd1);
        idle(1'b0);
        chk("bb3_addr", 32'(bus.rf_waddr_o), 32'd7);
        chk("bb3_data", bus.rf_wdata_o, 32'h0000_BBBB);
        idle(1'b0);
        chk("bb4_cnt", 32'(bus.dbg_count_o), 32'd0);

        // Write-back priority, FIFO fill, drain
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd1, 32'h11);
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b0, 5'd0, 32'd0);
        chk("wb_addr", 32'(bus.rf_waddr_o), 32'd5);
        chk("wb_data", bus.rf_wdata_o, 32'h1234_5678);
        chk("wb_cnt",  32'(bus.dbg_count_o), 32'd1);
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd2, 32'h22);
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd4, 32'h44);
        chk("full_rdy", 32'(bus.dbg_ready_o), 32'd0);
        chk("full_cnt", 32'(bus.dbg_count_o), 32'd2);
        step(1'b0, 1'b1, 5'd5, 32'h1234_5678, 1'b1, 5'd4, 32'h44);
        chk("full_cnt2", 32'(bus.dbg_count_o), 32'd2);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        chk("drain1_addr", 32'(bus.rf_waddr_o), 32'd1);
        chk("drain1_rdy",  32'(bus.dbg_ready_o), 32'd0);
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h44);
        chk("drain2_addr", 32'(bus.rf_waddr_o), 32'd2);
        chk("drain2_rdy",  32'(bus.dbg_ready_o), 32'd1);
        idle(1'b0);
        chk("drain3_addr", 32'(bus.rf_waddr_o), 32'd4);
        chk("drain3_cnt",  32'(bus.dbg_count_o), 32'd1);
        idle(1'b0);
        chk("drain4_we", 32'(bus.rf_we_o), 32'd0);

        // Host write to r0 is popped but suppressed
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h0000_FFFF);
        idle(1'b0);
        chk("r0_we",  32'(bus.rf_we_o), 32'd0);
        chk("r0_cnt", 32'(bus.dbg_count_o), 32'd1);
        idle(1'b0);
        chk("r0_cnt2", 32'(bus.dbg_count_o), 32'd0);

        // Reset with a pending entry, then reset again mid-clear at idx 12
        step(1'b0, 1'b1, 5'd6, 32'h66, 1'b1, 5'd9, 32'h99);
        step(1'b0, 1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
        idle(1'b1);
        for (int k = 0; k < 13; k++) idle(1'b0);
        chk("mid_idx", 32'(bus.rf_waddr_o), 32'd12);
        idle(1'b1);
        idle(1'b0);
        chk("restart_addr", 32'(bus.rf_waddr_o), 32'd0);
        chk("restart_cnt",  32'(bus.dbg_count_o), 32'd0);
        for (int k = 0; k < 31; k++) idle(1'b0);

        // Randomized phase; host holds a request until it is accepted
        p_valid = 1'b0; p_a = 5'd0; p_d = 32'd0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!p_valid || m_accepted) begin
                p_valid = ($urandom_range(0, 99) < 60);
                p_a     = 5'($urandom_range(0, 31));
                p_d     = $urandom;
            end
            r_rst = ($urandom_range(0, 299) == 0);
            r_wb  = ($urandom_range(0, 99) < 50);
            drive(r_rst, r_wb, 5'($urandom_range(0, 31)), $urandom, p_valid, p_a, p_d);
            check_model();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
